seq_normalizer: RTL and testbench



---
 rtl/seq_normalizer.sv | 79 +++++++
 tb/tb_seq_normalizer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: finds the leading-zero count of a WIDTH-bit operand
// one left shift per cycle, returning the normalized word and its shift amount.
module seq_normalizer #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      work  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      shamt <= '0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE, so back-to-back has no bubble
        S_IDLE, S_DONE: begin
          if (start) begin
            if (data == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              out   <= '0;
              shamt <= '0;
              zero  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              work  <= data;
              count <= '0;
              zero  <= 1'b0;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (work[WIDTH-1]) begin
            state <= S_DONE;
            out   <= work;
            shamt <= count;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            work  <= {work[WIDTH-2:0], 1'b0};
            count <= count + SHAMT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// Bench for seq_normalizer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a leading-zero-count model.
module tb_seq_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [3:0]  shamt;
  logic        zero;

  int vectors;
  int miscompares;
  bit en;

  seq_normalizer #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy), .done(done), .out(out), .shamt(shamt), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz(input logic [15:0] v);
    int n = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  // Model: an accepted nonzero operand finishes clz+1 edges later
  bit          m_busy, m_done, m_zero;
  logic [15:0] m_out, p_out;
  logic [3:0]  m_sh, p_sh;
  int          rem;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_zero = 0; m_out = '0; m_sh = '0; rem = 0;
    end else begin
      m_done = 0;
      if (!m_busy && start) begin
        if (data == 16'h0) begin
          m_done = 1; m_out = '0; m_sh = '0; m_zero = 1;
        end else begin
          p_sh   = 4'(clz(data));
          p_out  = data << clz(data);
          m_zero = 0;
          rem    = clz(data) + 1;
          m_busy = 1;
        end
      end else if (m_busy) begin
        rem--;
        if (rem == 0) begin
          m_busy = 0; m_done = 1; m_out = p_out; m_sh = p_sh;
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      pin("model_busy",  {31'd0, busy}, {31'd0, m_busy});
      pin("model_done",  {31'd0, done}, {31'd0, m_done});
      pin("model_out",   {16'd0, out},  {16'd0, m_out});
      pin("model_shamt", {28'd0, shamt}, {28'd0, m_sh});
      pin("model_zero",  {31'd0, zero}, {31'd0, m_zero});
      pin("busy_and_done", {31'd0, busy & done}, 32'd0);
    end
  end

  // Apply inputs for one cycle, return at the next negedge
  task automatic drive(input bit s, input logic [15:0] d, input bit r);
    start = s; data = d; rst = r;
    @(negedge clk);
  endtask

  // Start an operation in cycle 0, optionally poke start with 0x1234 at cycle `poke`
  task automatic run_op(input string nm, input logic [15:0] d, input int exp_lat,
                        input logic [15:0] exp_out, input logic [3:0] exp_sh,
                        input bit exp_z, input int poke);
    int n;
    drive(1'b1, d, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      drive(n == poke, (n == poke) ? 16'h1234 : 16'($urandom), 1'b0);
      n++;
    end
    pin({nm, "_latency"}, n, exp_lat);
    pin({nm, "_out"}, {16'd0, out}, {16'd0, exp_out});
    pin({nm, "_shamt"}, {28'd0, shamt}, {28'd0, exp_sh});
    pin({nm, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; en = 0;
    start = 0; data = '0; rst = 1;
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b1);
    en = 1;
    pin("reset_state", {busy, done, zero, shamt, out}, 32'd0);

    // 0x8000: busy in cycle 1 only, done in cycle 2
    drive(1'b1, 16'h8000, 1'b0);
    pin("msb_busy_c1", {30'd0, busy, done}, 32'd2);
    drive(1'b0, 16'h0, 1'b0);
    pin("msb_done_c2", {30'd0, busy, done}, 32'd1);
    pin("msb_out", {16'd0, out}, 32'h8000);

    run_op("lsb",  16'h0001, 17, 16'h8000, 4'd15, 1'b0, -1);
    run_op("zero", 16'h0000, 1,  16'h0000, 4'd0,  1'b1, -1);
    run_op("ignore_busy", 16'h00F3, 10, 16'hF300, 4'd8, 1'b0, 3);

    // Back-to-back: start held, second operand presented on the DONE cycle
    drive(1'b1, 16'h4000, 1'b0);
    drive(1'b1, 16'h4000, 1'b0);
    drive(1'b1, 16'h4000, 1'b0);
    pin("b2b_first_done", {31'd0, done}, 32'd1);
    pin("b2b_first_shamt", {28'd0, shamt}, 32'd1);
    pin("b2b_first_out", {16'd0, out}, 32'h8000);
    run_op("b2b_second", 16'h0100, 9, 16'h8000, 4'd7, 1'b0, -1);

    // Mid-operation reset in cycle 4, fresh start in cycle 5
    drive(1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    pin("midreset_clear", {busy, done, zero, shamt, out}, 32'd0);
    run_op("after_reset", 16'h2000, 4, 16'h8000, 4'd2, 1'b0, -1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 9) == 0) d = '0;
      drive($urandom_range(0, 2) == 0, d, $urandom_range(0, 99) == 0);
    end

    // Drain so the last operation completes under observation
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      drive(1'b0, 16'h0, 1'b0);
      n++;
    end
    pin("drain_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
